// File: rtl/cpu_run_sequencer_pkg.sv
// Shared types and constants for the CPU run-level sequencer.
package cpu_run_sequencer_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        RESET_CPU,
        START,
        RUN,
        DRAIN,
        DONE
    } run_state_t;

    // The host may touch data memory only while the CPU is parked.
    function automatic logic hostOwnsState(input run_state_t s);
        return (s == IDLE) || (s == DONE);
    endfunction

endpackage

// File: rtl/cpu_run_sequencer_dmem_port_mux.sv
// Selects whether the host or the CPU drives the single data-memory port.
module cpu_run_sequencer_dmem_port_mux
    import cpu_run_sequencer_pkg::*;
(
    input  logic              cpuOwns,
    input  logic              hostReq,
    input  logic              hostWe,
    input  logic [WORD_W-1:0] hostAddr,
    input  logic [WORD_W-1:0] hostWdata,
    input  logic              cpuWe,
    input  logic [WORD_W-1:0] cpuAddr,
    input  logic [WORD_W-1:0] cpuWdata,
    output logic              memWe,
    output logic [WORD_W-1:0] memAddr,
    output logic [WORD_W-1:0] memWdata
);

    // Pure select; a host write only counts when it is an actual request.
    always_comb begin
        if (cpuOwns) begin
            memWe    = cpuWe;
            memAddr  = cpuAddr;
            memWdata = cpuWdata;
        end else begin
            memWe    = hostReq & hostWe;
            memAddr  = hostAddr;
            memWdata = hostWdata;
        end
    end

endmodule

// File: rtl/cpu_run_sequencer.sv
// Run-level controller: holds the CPU in reset while the host loads memory,
// starts it, waits for its end flag, drains late writes, then hands memory back.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | host owns memory, CPU held in reset
// RESET_CPU | CPU held in reset for RST_CYCLES cycles, CPU owns memory
// START     | CPU released, one-cycle start pulse
// RUN       | CPU executing, cycle_count advancing, watching end flag/timeout
// DRAIN     | pipeline writes still retiring for DRAIN_CYCLES cycles
// DONE      | CPU frozen in reset, host reads results
module cpu_run_sequencer
    import cpu_run_sequencer_pkg::*;
#(
    parameter int          RST_CYCLES     = 4,
    parameter int          DRAIN_CYCLES   = 3,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_go,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [WORD_W-1:0] host_addr,
    input  logic [WORD_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [WORD_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              cpu_reset,
    output logic              cpu_start,
    input  logic              cpu_mem_write,
    input  logic [WORD_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic [WORD_W-1:0] cpu_rdata,
    input  logic              end_flag,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       cycle_count
);

    localparam logic [31:0] RST_LOAD     = 32'(RST_CYCLES - 1);
    localparam logic [31:0] DRAIN_LOAD   = 32'(DRAIN_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

    run_state_t  state;
    run_state_t  stateNext;
    logic [31:0] phaseCnt;
    logic        cpuOwnsMem;
    logic        goAccept;
    logic        runTimeout;
    logic        hostRead;

    assign goAccept   = host_go & hostOwnsState(state);
    assign runTimeout = (state == RUN) && !end_flag && (cycle_count == TIMEOUT_LAST);
    assign host_gnt   = host_req & hostOwnsState(state);
    assign hostRead   = host_gnt & ~host_we;
    assign cpu_rdata  = mem_rdata;

    // State register; reset aborts any run and parks the CPU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state decode.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: if (host_go) stateNext = RESET_CPU;
            RESET_CPU:  if (phaseCnt == 32'd0) stateNext = START;
            START:      stateNext = RUN;
            RUN:        if (end_flag || runTimeout) stateNext = DRAIN;
            DRAIN:      if (phaseCnt == 32'd0) stateNext = DONE;
            default:    stateNext = IDLE;
        endcase
    end

    // Per-state outputs; CPU is in reset everywhere except START/RUN/DRAIN.
    always_comb begin
        cpu_reset  = 1'b1;
        cpu_start  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cpuOwnsMem = 1'b0;
        case (state)
            RESET_CPU: begin
                busy       = 1'b1;
                cpuOwnsMem = 1'b1;
            end
            START: begin
                cpu_reset  = 1'b0;
                cpu_start  = 1'b1;
                busy       = 1'b1;
                cpuOwnsMem = 1'b1;
            end
            RUN, DRAIN: begin
                cpu_reset  = 1'b0;
                busy       = 1'b1;
                cpuOwnsMem = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // One down-counter serves both the reset hold and the drain window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phaseCnt <= 32'd0;
        end else if (goAccept) begin
            phaseCnt <= RST_LOAD;
        end else if (state == RUN && stateNext == DRAIN) begin
            phaseCnt <= DRAIN_LOAD;
        end else if ((state == RESET_CPU || state == DRAIN) && phaseCnt != 32'd0) begin
            phaseCnt <= phaseCnt - 32'd1;
        end
    end

    // Run-length counter (saturating) and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= 32'd0;
            timeout     <= 1'b0;
        end else if (goAccept) begin
            cycle_count <= 32'd0;
            timeout     <= 1'b0;
        end else begin
            if (state == RUN && cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
            if (runTimeout) timeout <= 1'b1;
        end
    end

    // Host read data is captured at grant and presented the following cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            host_rvalid <= hostRead;
            if (hostRead) host_rdata <= mem_rdata;
        end
    end

    cpu_run_sequencer_dmem_port_mux uMux (
        .cpuOwns   (cpuOwnsMem),
        .hostReq   (host_req),
        .hostWe    (host_we),
        .hostAddr  (host_addr),
        .hostWdata (host_wdata),
        .cpuWe     (cpu_mem_write),
        .cpuAddr   (cpu_addr),
        .cpuWdata  (cpu_wdata),
        .memWe     (mem_we),
        .memAddr   (mem_addr),
        .memWdata  (mem_wdata)
    );

endmodule
